// File: rtl/pc_sequenciador_if.sv
// pc_sequenciador_if -- bus between the PC sequencer and whoever drives it.
//
// Signals:
//   EscrevePC      : update enable (0 = stall, all sequencer state held)
//   modo           : next-PC operation select (SEQ/DESVIO/SALTO/CHAMADA/RETORNO)
//   valorEntradaPC : jump target or two's-complement branch offset
//   valorPC        : current PC (registered)
//   ocupacao       : number of valid return-stack entries (registered)
//   pilhaVazia     : return stack empty
//   pilhaCheia     : return stack full
//   erroPilha      : sticky overflow/underflow flag
//
// Modports: master drives the controls and observes state; slave is the sequencer.
interface pc_sequenciador_if #(
  parameter int LARGURA    = 8,
  parameter int PROF_PILHA = 4
);
  localparam int OCW = $clog2(PROF_PILHA + 1);

  logic               EscrevePC;
  logic [2:0]         modo;
  logic [LARGURA-1:0] valorEntradaPC;
  logic [LARGURA-1:0] valorPC;
  logic [OCW-1:0]     ocupacao;
  logic               pilhaVazia;
  logic               pilhaCheia;
  logic               erroPilha;

  modport master (
    output EscrevePC, modo, valorEntradaPC,
    input  valorPC, ocupacao, pilhaVazia, pilhaCheia, erroPilha
  );

  modport slave (
    input  EscrevePC, modo, valorEntradaPC,
    output valorPC, ocupacao, pilhaVazia, pilhaCheia, erroPilha
  );
endinterface

// File: rtl/pc_sequenciador.sv
// pc_sequenciador -- program-counter sequencer with a return-address stack.
//
// Each enabled rising edge applies one operation:
//   000 SEQ      PC <= PC + PASSO
//   001 DESVIO   PC <= PC + offset (two's complement)
//   010 SALTO    PC <= target
//   011 CHAMADA  push PC + PASSO, PC <= target (overflow: nothing moves, error set)
//   100 RETORNO  PC <= top of stack, pop       (underflow: nothing moves, error set)
//   101-111      no operation
// All arithmetic wraps modulo 2^LARGURA silently.
//
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset (PC <= VETOR_RESET, stack emptied, error cleared)
//   bus   : pc_sequenciador_if.slave (controls in, PC/stack status out)
module pc_sequenciador #(
  parameter int                 LARGURA     = 8,
  parameter int                 PASSO       = 1,
  parameter int                 PROF_PILHA  = 4,
  parameter logic [LARGURA-1:0] VETOR_RESET = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  pc_sequenciador_if.slave        bus
);
  localparam int OCW = $clog2(PROF_PILHA + 1);
  localparam int IW  = (PROF_PILHA > 1) ? $clog2(PROF_PILHA) : 1;

  localparam logic [LARGURA-1:0] PASSO_V = LARGURA'(PASSO);
  localparam logic [OCW-1:0]     CHEIA_V = OCW'(PROF_PILHA);
  localparam logic [OCW-1:0]     UM      = OCW'(1);

  localparam logic [2:0] OP_SEQ     = 3'b000;
  localparam logic [2:0] OP_DESVIO  = 3'b001;
  localparam logic [2:0] OP_SALTO   = 3'b010;
  localparam logic [2:0] OP_CHAMADA = 3'b011;
  localparam logic [2:0] OP_RETORNO = 3'b100;

  logic [LARGURA-1:0] pc_q, pc_d;
  logic [OCW-1:0]     ocup_q, ocup_d;
  logic               erro_q, erro_d;
  logic [LARGURA-1:0] pilha_q [PROF_PILHA];
  logic [LARGURA-1:0] pilha_d [PROF_PILHA];

  logic               vazia, cheia, push;
  logic [LARGURA-1:0] pc_mais_passo;
  logic [IW-1:0]      push_idx, topo_idx;
  logic [LARGURA-1:0] topo;

  assign vazia         = (ocup_q == '0);
  assign cheia         = (ocup_q == CHEIA_V);
  assign pc_mais_passo = pc_q + PASSO_V;

  // The stack grows upward: the next free slot is at index ocupacao, the
  // top at ocupacao-1. Both indices are only used when they are in range
  // (push only when not full, pop only when not empty).
  assign push_idx = IW'(ocup_q);
  assign topo_idx = IW'(ocup_q - UM);
  assign topo     = pilha_q[topo_idx];

  always_comb begin
    pc_d   = pc_q;
    ocup_d = ocup_q;
    erro_d = erro_q;
    push   = 1'b0;
    if (bus.EscrevePC) begin
      case (bus.modo)
        OP_SEQ:    pc_d = pc_mais_passo;
        // Unsigned modular add is identical to a two's-complement add here.
        OP_DESVIO: pc_d = pc_q + bus.valorEntradaPC;
        OP_SALTO:  pc_d = bus.valorEntradaPC;
        OP_CHAMADA: begin
          if (cheia) begin
            erro_d = 1'b1;
          end else begin
            push   = 1'b1;
            ocup_d = ocup_q + UM;
            pc_d   = bus.valorEntradaPC;
          end
        end
        OP_RETORNO: begin
          if (vazia) begin
            erro_d = 1'b1;
          end else begin
            ocup_d = ocup_q - UM;
            pc_d   = topo;
          end
        end
        default: ;
      endcase
    end
  end

  // Stack storage is not reset: entries above ocupacao are never read.
  always_comb begin
    for (int i = 0; i < PROF_PILHA; i++) begin
      pilha_d[i] = (push && (push_idx == IW'(i))) ? pc_mais_passo : pilha_q[i];
    end
  end

  always_ff @(posedge clock) begin
    pilha_q <= pilha_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= VETOR_RESET;
      ocup_q <= '0;
      erro_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ocup_q <= ocup_d;
      erro_q <= erro_d;
    end
  end

  assign bus.valorPC    = pc_q;
  assign bus.ocupacao   = ocup_q;
  assign bus.pilhaVazia = vazia;
  assign bus.pilhaCheia = cheia;
  assign bus.erroPilha  = erro_q;
endmodule

// File: tb/tb_pc_sequenciador.sv
// Testbench for pc_sequenciador. A behavioural model (queue-based stack)
// computes the expected state when each step is driven; the expectation is
// queued and popped once the DUT has taken the edge. A second instance with
// PASSO=4 and a non-zero reset vector covers the parameterised paths.
module tb_pc_sequenciador;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_sequenciador_if #(.LARGURA(8), .PROF_PILHA(4)) b  ();
  pc_sequenciador_if #(.LARGURA(8), .PROF_PILHA(4)) b4 ();

  pc_sequenciador #(.LARGURA(8), .PASSO(1), .PROF_PILHA(4), .VETOR_RESET(8'd0)) u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (b.slave)
  );

  pc_sequenciador #(.LARGURA(8), .PASSO(4), .PROF_PILHA(4), .VETOR_RESET(8'd16)) u_dut4 (
    .clock (clk),
    .reset (rst),
    .bus   (b4.slave)
  );

  typedef struct {
    logic [7:0] pc;
    logic [7:0] oc;
    logic       vaz;
    logic       chei;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_err;
  int         errors = 0;
  int         checks = 0;
  int         step_n = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one step, update the model, queue the expectation, then compare
  // the DUT against the popped expectation one time unit after the edge.
  task automatic do_op(input logic r, input logic en, input logic [2:0] md, input logic [7:0] v);
    exp_t e;
    rst              = r;
    b.EscrevePC      = en;
    b.modo           = md;
    b.valorEntradaPC = v;
    if (r) begin
      m_pc = 8'd0;
      m_stk.delete();
      m_err = 1'b0;
    end else if (en) begin
      case (md)
        3'd0: m_pc = m_pc + 8'd1;
        3'd1: m_pc = m_pc + v;
        3'd2: m_pc = v;
        3'd3: begin
          if (m_stk.size() == 4) m_err = 1'b1;
          else begin
            m_stk.push_back(m_pc + 8'd1);
            m_pc = v;
          end
        end
        3'd4: begin
          if (m_stk.size() == 0) m_err = 1'b1;
          else m_pc = m_stk.pop_back();
        end
        default: ;
      endcase
    end
    e.pc   = m_pc;
    e.oc   = 8'(m_stk.size());
    e.vaz  = (m_stk.size() == 0);
    e.chei = (m_stk.size() == 4);
    e.err  = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step_n++;
    e = exp_q.pop_front();
    $display("step %0d rst=%0b en=%0b modo=%0d val=%0d -> pc=%0d oc=%0d vaz=%0b chei=%0b err=%0b",
             step_n, r, en, md, v, b.valorPC, b.ocupacao, b.pilhaVazia, b.pilhaCheia, b.erroPilha);
    chk($sformatf("s%0d_pc", step_n),   b.valorPC,          e.pc);
    chk($sformatf("s%0d_oc", step_n),   8'(b.ocupacao),     e.oc);
    chk($sformatf("s%0d_vaz", step_n),  8'(b.pilhaVazia),   8'(e.vaz));
    chk($sformatf("s%0d_chei", step_n), 8'(b.pilhaCheia),   8'(e.chei));
    chk($sformatf("s%0d_err", step_n),  8'(b.erroPilha),    8'(e.err));
  endtask

  task automatic op4(input logic en, input logic [2:0] md, input logic [7:0] v, input logic [7:0] exp_pc, input string tag);
    b4.EscrevePC      = en;
    b4.modo           = md;
    b4.valorEntradaPC = v;
    @(posedge clk);
    #1;
    $display("passo4 %s modo=%0d val=%0d -> pc=%0d", tag, md, v, b4.valorPC);
    chk(tag, b4.valorPC, exp_pc);
  endtask

  initial begin
    rst = 1'b1;
    b.EscrevePC = 1'b0; b.modo = 3'd0; b.valorEntradaPC = 8'd0;
    b4.EscrevePC = 1'b1; b4.modo = 3'd3; b4.valorEntradaPC = 8'd99;
    m_pc = 8'd0; m_err = 1'b0;

    // Reset wins over a CHAMADA sampled on the same edge.
    do_op(1'b1, 1'b1, 3'd3, 8'd55);
    chk("rst_pc_literal", b.valorPC, 8'd0);
    chk("rst_vetor4", b4.valorPC, 8'd16);
    chk("rst_oc4", 8'(b4.ocupacao), 8'd0);
    b4.EscrevePC = 1'b0;

    // SEQ x3 then two stalled cycles with active-looking modo.
    do_op(1'b0, 1'b1, 3'd0, 8'd0);
    do_op(1'b0, 1'b1, 3'd0, 8'd0);
    do_op(1'b0, 1'b1, 3'd0, 8'd0);
    do_op(1'b0, 1'b0, 3'd1, 8'd7);
    do_op(1'b0, 1'b0, 3'd4, 8'd0);
    chk("stall_pc_literal", b.valorPC, 8'd3);

    // Signed branch and wrap-around.
    do_op(1'b0, 1'b1, 3'd2, 8'd250);
    do_op(1'b0, 1'b1, 3'd1, 8'hF6);
    chk("desvio_neg_literal", b.valorPC, 8'd240);
    do_op(1'b0, 1'b1, 3'd1, 8'd20);
    chk("desvio_wrap_literal", b.valorPC, 8'd4);
    do_op(1'b0, 1'b1, 3'd2, 8'd255);
    do_op(1'b0, 1'b1, 3'd0, 8'd0);
    chk("seq_wrap_literal", b.valorPC, 8'd0);

    // Nested call/return.
    do_op(1'b0, 1'b1, 3'd2, 8'd10);
    do_op(1'b0, 1'b1, 3'd3, 8'd100);
    do_op(1'b0, 1'b1, 3'd3, 8'd200);
    do_op(1'b0, 1'b1, 3'd4, 8'd0);
    chk("ret1_literal", b.valorPC, 8'd101);
    do_op(1'b0, 1'b1, 3'd4, 8'd0);
    chk("ret2_literal", b.valorPC, 8'd11);

    // Fill, overflow, then unwind in LIFO order.
    do_op(1'b0, 1'b1, 3'd3, 8'd20);
    do_op(1'b0, 1'b1, 3'd3, 8'd30);
    do_op(1'b0, 1'b1, 3'd3, 8'd40);
    do_op(1'b0, 1'b1, 3'd3, 8'd50);
    do_op(1'b0, 1'b1, 3'd3, 8'd77);
    chk("overflow_pc_literal", b.valorPC, 8'd50);
    do_op(1'b0, 1'b0, 3'd4, 8'd0);
    do_op(1'b0, 1'b1, 3'd4, 8'd0);
    do_op(1'b0, 1'b1, 3'd4, 8'd0);
    do_op(1'b0, 1'b1, 3'd4, 8'd0);
    do_op(1'b0, 1'b1, 3'd4, 8'd0);
    chk("unwind_pc_literal", b.valorPC, 8'd12);

    // Underflow keeps PC, error stays sticky; reset clears it.
    do_op(1'b0, 1'b1, 3'd4, 8'd0);
    do_op(1'b0, 1'b1, 3'd0, 8'd0);
    do_op(1'b1, 1'b0, 3'd0, 8'd0);

    // Underflow on a fresh empty stack, then reset again.
    do_op(1'b0, 1'b1, 3'd4, 8'd0);
    chk("underflow_err_literal", 8'(b.erroPilha), 8'd1);
    do_op(1'b1, 1'b0, 3'd0, 8'd0);

    // Reserved encodings are no-ops even with a non-empty stack.
    do_op(1'b0, 1'b1, 3'd3, 8'd9);
    do_op(1'b0, 1'b1, 3'd5, 8'd33);
    do_op(1'b0, 1'b1, 3'd6, 8'd44);
    do_op(1'b0, 1'b1, 3'd7, 8'd55);
    do_op(1'b0, 1'b1, 3'd4, 8'd0);

    // Reset mid call sequence empties the stack; RETORNO then underflows.
    do_op(1'b0, 1'b1, 3'd3, 8'd60);
    do_op(1'b0, 1'b1, 3'd3, 8'd70);
    do_op(1'b1, 1'b1, 3'd4, 8'd0);
    do_op(1'b0, 1'b1, 3'd4, 8'd0);

    // PASSO=4 instance: it held its reset vector while idle.
    chk("p4_hold", b4.valorPC, 8'd16);
    op4(1'b1, 3'd2, 8'd252, 8'd252, "p4_salto");
    op4(1'b1, 3'd0, 8'd0,   8'd0,   "p4_seq_wrap");
    op4(1'b1, 3'd2, 8'd252, 8'd252, "p4_salto2");
    op4(1'b1, 3'd3, 8'd5,   8'd5,   "p4_call");
    chk("p4_oc", 8'(b4.ocupacao), 8'd1);
    op4(1'b1, 3'd4, 8'd0,   8'd0,   "p4_ret_wrapped");
    op4(1'b1, 3'd0, 8'd0,   8'd4,   "p4_seq");

    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_sequenciador.md
PC_SEQUENCIADOR -- requirements
Module: pc_sequenciador

Interface
REQ-001 Parameter LARGURA, default 8: PC and operand width in bits, minimum 2.
REQ-002 Parameter PASSO, default 1: sequential increment, range 1 to 2^LARGURA-1.
REQ-003 Parameter PROF_PILHA, default 4: return-address stack depth, minimum 1.
REQ-004 Parameter VETOR_RESET, default 0: PC value loaded on reset.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 EscrevePC  input  1  update enable; 0 = stall, all state held.
REQ-008 modo  input  3  next-PC operation select, encodings per REQ-013.
REQ-009 valorEntradaPC  input  LARGURA  jump target or signed branch offset.
REQ-010 valorPC  output  LARGURA  current PC, registered.
REQ-011 ocupacao  output  clog2(PROF_PILHA+1)  number of valid stack entries, registered.
REQ-012 pilhaVazia, pilhaCheia, erroPilha  output  1 each  stack empty, stack full, sticky stack-error flag.

Function
REQ-013 With EscrevePC=1, each rising edge applies one operation selected by modo:
- 000 SEQ: PC <= PC+PASSO.
- 001 DESVIO: PC <= PC+valorEntradaPC, operand treated as two's complement.
- 010 SALTO: PC <= valorEntradaPC.
- 011 CHAMADA: push PC+PASSO, then PC <= valorEntradaPC.
- 100 RETORNO: PC <= top of stack, then pop.
- 101-111 reserved: PC and stack held, erroPilha unaffected.
REQ-014 All PC arithmetic is modulo 2^LARGURA; wrap-around is silent and raises no flag.
REQ-015 Latency is one cycle: valorPC shows the new value immediately after the edge on which the operation is sampled.
REQ-016 With EscrevePC=0, valorPC, stack contents, ocupacao and erroPilha hold, regardless of modo.
REQ-017 The stack is LIFO; ocupacao increments on a successful CHAMADA and decrements on a successful RETORNO.
REQ-018 pilhaVazia = (ocupacao==0) and pilhaCheia = (ocupacao==PROF_PILHA), both derived combinationally from the registered count.
REQ-019 CHAMADA while pilhaCheia=1 is an overflow: no push, PC unchanged, erroPilha set.
REQ-020 RETORNO while pilhaVazia=1 is an underflow: no pop, PC unchanged, erroPilha set.
REQ-021 erroPilha, once set, stays 1 until reset.
REQ-022 CHAMADA pushes PC+PASSO computed modulo 2^LARGURA; a wrapped return address is legal.
REQ-023 Stack entries above ocupacao are don't-care and never appear on valorPC.

Reset
REQ-024 When reset=1 at a rising edge: valorPC <= VETOR_RESET, ocupacao <= 0, erroPilha <= 0.
REQ-025 reset overrides EscrevePC and modo; any operation sampled on the same edge is discarded.
REQ-026 Reset during an in-progress CHAMADA/RETORNO sequence empties the stack; a following RETORNO is an underflow.
REQ-027 Outputs are defined only from the first reset edge; no power-up value is guaranteed before it.

Verification
Default parameters (LARGURA=8, PASSO=1, PROF_PILHA=4, VETOR_RESET=0) apply unless stated.
REQ-028 Reset, then SEQ x3 -> valorPC 0,1,2,3; then EscrevePC=0 for 2 cycles -> valorPC holds 3.
REQ-029 PC=250, DESVIO with 8'hF6 (-10) -> 240; DESVIO with 20 -> 4 (wrap); SALTO 255 then SEQ -> 0.
REQ-030 PC=10, CHAMADA 100 -> PC=100, ocupacao=1; CHAMADA 200 -> PC=200; RETORNO -> 101; RETORNO -> 11, pilhaVazia=1, erroPilha=0.
REQ-031 Four CHAMADAs to fill the stack -> pilhaCheia=1; fifth CHAMADA 77 -> PC unchanged, ocupacao=4, erroPilha=1; four RETORNOs are then correct LIFO.
REQ-032 Empty stack, RETORNO -> PC unchanged, erroPilha=1; SEQ -> PC+1, erroPilha stays 1; reset -> PC=0, erroPilha=0.
REQ-033 reset=1 with EscrevePC=1 and modo=CHAMADA on the same edge -> PC=VETOR_RESET, ocupacao=0; PASSO=4, PC=252, SEQ -> 0.
